// File: rtl/ram_port_ctrl.sv
// ram_port_ctrl: sequences single word reads/writes from a simple core bus onto a synchronous RAM port.
// Optional macro RAM_PORT_POSTED_WRITE_EN: posted writes, and new requests are taken during the write cycle.
module ram_port_ctrl #(
    parameter int          DATA_W  = 32,
    parameter int          ADDR_W  = 10,
    parameter int          RD_LAT  = 1,
    parameter logic [31:0] IO_BASE = 32'hFFFF_0000
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [31:0]         cpu_addr,
    input  logic [DATA_W-1:0]   cpu_wdata,
    input  logic [DATA_W/8-1:0] cpu_wmask,
    input  logic                cpu_rstrb,
    output logic [DATA_W-1:0]   cpu_rdata,
    output logic                cpu_rbusy,
    output logic                cpu_wbusy,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic [DATA_W-1:0]   ram_wdata,
    output logic                ram_wen,
    output logic                ram_rden,
    output logic [DATA_W/8-1:0] ram_byteena,
    input  logic [DATA_W-1:0]   ram_rdata,
    output logic                oor_err
);
    localparam int MASK_W = DATA_W / 8;
    localparam int BL     = $clog2(MASK_W);
    localparam int CNT_W  = $clog2(RD_LAT + 1);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] RD_ISSUE = 2'd1;
    localparam logic [1:0] RD_WAIT  = 2'd2;
    localparam logic [1:0] WR       = 2'd3;

`ifdef RAM_PORT_POSTED_WRITE_EN
    localparam logic POSTED = 1'b1;
`else
    localparam logic POSTED = 1'b0;
`endif

    logic [1:0]        state_r, state_s;
    logic [CNT_W-1:0]  cnt_r, cnt_s;
    logic              rbusy_r, rbusy_s;
    logic              wbusy_r, wbusy_s;
    logic [DATA_W-1:0] rdata_s;
    logic [ADDR_W-1:0] addr_s;
    logic [DATA_W-1:0] wdata_s;
    logic [MASK_W-1:0] be_s;
    logic              wen_s, rden_s, oor_s;
    logic              accept_en_s, rd_req_s, wr_req_s, out_of_range_s;
    logic [ADDR_W-1:0] word_addr_s;

    // Request decode; a read strobe always wins over a simultaneous write mask.
    always_comb begin
        accept_en_s    = (state_r == IDLE) || (POSTED && (state_r == WR));
        rd_req_s       = accept_en_s && cpu_rstrb;
        wr_req_s       = accept_en_s && !cpu_rstrb && (|cpu_wmask);
        out_of_range_s = (cpu_addr >= IO_BASE);
        word_addr_s    = cpu_addr[ADDR_W+BL-1:BL];
    end

    // Next-state and next-output computation; every RAM strobe is registered from here.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        rbusy_s = rbusy_r;
        wbusy_s = 1'b0;
        rdata_s = cpu_rdata;
        addr_s  = ram_addr;
        wdata_s = '0;
        be_s    = '0;
        wen_s   = 1'b0;
        rden_s  = 1'b0;
        oor_s   = 1'b0;
        case (state_r)
            IDLE: begin
                state_s = IDLE;
            end
            RD_ISSUE: begin
                state_s = RD_WAIT;
                cnt_s   = CNT_W'(RD_LAT);
            end
            RD_WAIT: begin
                // Capture on the last wait cycle, when ram_rdata is valid.
                if (cnt_r <= CNT_W'(1)) begin
                    state_s = IDLE;
                    cnt_s   = '0;
                    rdata_s = ram_rdata;
                    rbusy_s = 1'b0;
                end else begin
                    cnt_s = cnt_r - CNT_W'(1);
                end
            end
            WR: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
                cnt_s   = '0;
                rbusy_s = 1'b0;
            end
        endcase
        if (rd_req_s || wr_req_s) begin
            if (out_of_range_s) begin
                state_s = IDLE;
                oor_s   = 1'b1;
                if (rd_req_s) begin
                    rdata_s = '0;
                end else begin
                    rdata_s = cpu_rdata;
                end
            end else if (rd_req_s) begin
                state_s = RD_ISSUE;
                addr_s  = word_addr_s;
                rbusy_s = 1'b1;
                rden_s  = 1'b1;
            end else begin
                state_s = WR;
                addr_s  = word_addr_s;
                wdata_s = cpu_wdata;
                be_s    = cpu_wmask;
                wen_s   = 1'b1;
                wbusy_s = !POSTED;
            end
        end else begin
            oor_s = 1'b0;
        end
    end

    // State, counter and all registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= IDLE;
            cnt_r       <= '0;
            rbusy_r     <= 1'b0;
            wbusy_r     <= 1'b0;
            cpu_rdata   <= '0;
            ram_addr    <= '0;
            ram_wdata   <= '0;
            ram_byteena <= '0;
            ram_wen     <= 1'b0;
            ram_rden    <= 1'b0;
            oor_err     <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            rbusy_r     <= rbusy_s;
            wbusy_r     <= wbusy_s;
            cpu_rdata   <= rdata_s;
            ram_addr    <= addr_s;
            ram_wdata   <= wdata_s;
            ram_byteena <= be_s;
            ram_wen     <= wen_s;
            ram_rden    <= rden_s;
            oor_err     <= oor_s;
        end
    end

    // Busy outputs; with posted writes a request taken during WR also stalls the core that cycle.
    always_comb begin
        if (POSTED && (state_r == WR) && !out_of_range_s) begin
            cpu_rbusy = rbusy_r || rd_req_s;
            cpu_wbusy = wbusy_r || wr_req_s;
        end else begin
            cpu_rbusy = rbusy_r;
            cpu_wbusy = wbusy_r;
        end
    end
endmodule

// File: tb/tb_ram_port_ctrl.sv
// Scoreboard bench for ram_port_ctrl: two instances (RD_LAT 1 and 3) share one core stimulus,
// each driving its own behavioural RAM; a single monitor checks both against expected queues.
module tb_ram_port_ctrl;
    localparam int K_READ = 0, K_OOR = 1, K_ABORT = 2;
`ifdef RAM_PORT_POSTED_WRITE_EN
    localparam bit POSTED = 1'b1;
`else
    localparam bit POSTED = 1'b0;
`endif

    typedef struct {
        int          kind;
        logic [9:0]  addr;
        logic [31:0] data;
        logic        rd;
    } ev_t;
    typedef struct {
        logic [9:0]  addr;
        logic [31:0] data;
        logic [3:0]  mask;
        logic        wbusy;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [31:0] cpu_addr, cpu_wdata;
    logic [3:0]  cpu_wmask;
    logic        cpu_rstrb;

    logic [31:0] cpu_rdata_a [2];
    logic        rbusy_a [2];
    logic        wbusy_a [2];
    logic [9:0]  ram_addr_a [2];
    logic [31:0] ram_wdata_a [2];
    logic        ram_wen_a [2];
    logic        ram_rden_a [2];
    logic [3:0]  ram_be_a [2];
    logic [31:0] ram_rdata_a [2];
    logic        oor_a [2];

    logic [31:0] mem [2][1024];
    logic [31:0] pipe [2][4];

    ev_t exp_ev[$];
    wr_t exp_wr[$];
    int  n_vec = 0;
    int  n_err = 0;
    int  ev_idx [2] = '{0, 0};
    int  wr_idx [2] = '{0, 0};
    int  bcnt [2] = '{0, 0};
    int  rcnt [2] = '{0, 0};
    logic [31:0] last_rd [2] = '{32'h0, 32'h0};
    bit  end_chk = 1'b0;
    bit  end_done = 1'b0;

    always #5 clk = ~clk;

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        ram_port_ctrl #(.DATA_W(32), .ADDR_W(10), .RD_LAT(g == 0 ? 1 : 3), .IO_BASE(32'hFFFF_0000)) u_dut (
            .clk(clk), .reset_n(reset_n), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
            .cpu_wmask(cpu_wmask), .cpu_rstrb(cpu_rstrb), .cpu_rdata(cpu_rdata_a[g]),
            .cpu_rbusy(rbusy_a[g]), .cpu_wbusy(wbusy_a[g]), .ram_addr(ram_addr_a[g]),
            .ram_wdata(ram_wdata_a[g]), .ram_wen(ram_wen_a[g]), .ram_rden(ram_rden_a[g]),
            .ram_byteena(ram_be_a[g]), .ram_rdata(ram_rdata_a[g]), .oor_err(oor_a[g]));
        assign ram_rdata_a[g] = pipe[g][(g == 0 ? 1 : 3) - 1];
    end

    // Behavioural RAMs: byte-enabled writes, reads valid RD_LAT cycles after ram_rden, garbage otherwise.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (ram_wen_a[i])
                for (int b = 0; b < 4; b++)
                    if (ram_be_a[i][b]) mem[i][ram_addr_a[i]][8*b +: 8] <= ram_wdata_a[i][8*b +: 8];
            pipe[i][0] <= ram_rden_a[i] ? mem[i][ram_addr_a[i]] : 32'hBAD0_BAD0;
            for (int k = 1; k < 4; k++) pipe[i][k] <= pipe[i][k-1];
        end
    end

    task automatic chk(input string name, input int inst, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[lat%0d] @%0t: got %0h, expected %0h", name, lat_of(inst), $time, act, exp);
        end
    endtask

    // Monitor: compares every DUT event against the scoreboard, per instance.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!reset_n) begin
                chk("rst_rdata", i, cpu_rdata_a[i], 64'h0);
                chk("rst_wdata", i, ram_wdata_a[i], 64'h0);
                chk("rst_ctrl", i, {rbusy_a[i], wbusy_a[i], ram_wen_a[i], ram_rden_a[i], ram_be_a[i],
                                    oor_a[i], ram_addr_a[i]}, 64'h0);
                if (bcnt[i] != 0 || rcnt[i] != 0) begin
                    if (ev_idx[i] < exp_ev.size()) begin
                        chk("abort_kind", i, exp_ev[ev_idx[i]].kind, K_ABORT);
                        ev_idx[i]++;
                    end else chk("unexpected_abort", i, 1, 0);
                end
                bcnt[i] = 0;
                rcnt[i] = 0;
                last_rd[i] = 32'h0;
            end else begin
                chk("wen_rden_excl", i, ram_wen_a[i] & ram_rden_a[i], 0);
                if (!ram_wen_a[i]) chk("idle_wr_outputs", i, {wbusy_a[i], ram_be_a[i], ram_wdata_a[i]}, 0);
                if (ram_wen_a[i]) begin
                    if (wr_idx[i] < exp_wr.size()) begin
                        chk("wr_addr", i, ram_addr_a[i], exp_wr[wr_idx[i]].addr);
                        chk("wr_data", i, ram_wdata_a[i], exp_wr[wr_idx[i]].data);
                        chk("wr_mask", i, ram_be_a[i], exp_wr[wr_idx[i]].mask);
                        chk("wr_busy", i, wbusy_a[i], exp_wr[wr_idx[i]].wbusy);
                        wr_idx[i]++;
                    end else chk("unexpected_wen", i, 1, 0);
                end
                if (ram_rden_a[i]) begin
                    rcnt[i]++;
                    if (ev_idx[i] < exp_ev.size() && exp_ev[ev_idx[i]].kind != K_OOR)
                        chk("rd_addr", i, ram_addr_a[i], exp_ev[ev_idx[i]].addr);
                    else chk("unexpected_rden", i, 1, 0);
                end
                if (rbusy_a[i]) bcnt[i]++;
                else if (bcnt[i] != 0) begin
                    if (ev_idx[i] < exp_ev.size() && exp_ev[ev_idx[i]].kind == K_READ) begin
                        chk("rd_data", i, cpu_rdata_a[i], exp_ev[ev_idx[i]].data);
                        chk("rbusy_cycles", i, bcnt[i], lat_of(i) + 1);
                        chk("rden_cycles", i, rcnt[i], 1);
                        last_rd[i] = exp_ev[ev_idx[i]].data;
                        ev_idx[i]++;
                    end else chk("unexpected_read", i, 1, 0);
                    bcnt[i] = 0;
                    rcnt[i] = 0;
                end
                if (oor_a[i]) begin
                    if (ev_idx[i] < exp_ev.size() && exp_ev[ev_idx[i]].kind == K_OOR) begin
                        chk("oor_busy", i, {rbusy_a[i], wbusy_a[i]}, 0);
                        if (exp_ev[ev_idx[i]].rd) begin
                            chk("oor_rdata", i, cpu_rdata_a[i], 0);
                            last_rd[i] = 32'h0;
                        end
                        ev_idx[i]++;
                    end else chk("unexpected_oor", i, 1, 0);
                end
                chk("rdata_hold", i, cpu_rdata_a[i], last_rd[i]);
            end
            if (end_chk && !end_done) begin
                chk("events_seen", i, ev_idx[i], exp_ev.size());
                chk("writes_seen", i, wr_idx[i], exp_wr.size());
                chk("no_read_pending", i, bcnt[i], 0);
            end
        end
        if (end_chk) end_done = 1'b1;
    end

    task automatic wait_idle();
        int n = 0;
        while (rbusy_a[0] | rbusy_a[1] | wbusy_a[0] | wbusy_a[1]) begin
            @(posedge clk); #2;
            n++;
            if (n > 50) begin
                $display("FAIL wait_idle: busy still high after %0d cycles, expected idle", n);
                $fatal(1, "timeout");
            end
        end
    endtask

    task automatic issue(input logic rd, input logic [31:0] addr, input logic [31:0] data, input logic [3:0] mask);
        @(posedge clk); #2;
        cpu_addr = addr; cpu_wdata = data; cpu_wmask = mask; cpu_rstrb = rd;
        @(posedge clk); #2;
        cpu_rstrb = 1'b0; cpu_wmask = 4'h0;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] mask);
        wr_t w;
        w.addr = addr[11:2]; w.data = data; w.mask = mask; w.wbusy = !POSTED;
        exp_wr.push_back(w);
        issue(1'b0, addr, data, mask);
        wait_idle();
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [31:0] exp, input logic [3:0] mask);
        ev_t e;
        e.kind = K_READ; e.addr = addr[11:2]; e.data = exp; e.rd = 1'b1;
        exp_ev.push_back(e);
        issue(1'b1, addr, 32'h5555_5555, mask);
        wait_idle();
    endtask

    task automatic do_oor(input logic rd, input logic [31:0] addr);
        ev_t e;
        e.kind = K_OOR; e.addr = 10'h0; e.data = 32'h0; e.rd = rd;
        exp_ev.push_back(e);
        issue(rd, addr, 32'h1234_5678, 4'hF);
        wait_idle();
    endtask

`ifdef RAM_PORT_POSTED_WRITE_EN
    task automatic posted_pair(input logic [31:0] a1, input logic [31:0] d1, input logic [31:0] a2,
                               input logic [31:0] d2, input bit abort2);
        wr_t w;
        w.addr = a1[11:2]; w.data = d1; w.mask = 4'hF; w.wbusy = 1'b1;
        exp_wr.push_back(w);
        if (!abort2) begin
            w.addr = a2[11:2]; w.data = d2; w.wbusy = 1'b0;
            exp_wr.push_back(w);
        end
        @(posedge clk); #2; cpu_addr = a1; cpu_wdata = d1; cpu_wmask = 4'hF;
        @(posedge clk); #2; cpu_addr = a2; cpu_wdata = d2;
        @(posedge clk); #2; cpu_wmask = 4'h0;
        if (abort2) begin
            reset_n = 1'b0;
            repeat (2) @(posedge clk);
            #2 reset_n = 1'b1;
            repeat (6) @(posedge clk);
            #2;
        end
        wait_idle();
    endtask
`endif

    initial begin
        ev_t e;
        cpu_addr = 32'h0; cpu_wdata = 32'h0; cpu_wmask = 4'h0; cpu_rstrb = 1'b0;
        #1 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b1;

        do_write(32'h0000_0010, 32'hDEAD_BEEF, 4'hF);
        do_read(32'h0000_0010, 32'hDEAD_BEEF, 4'h0);
        do_write(32'h0000_0040, 32'h1122_3344, 4'hF);
        do_write(32'h0000_0040, 32'h0000_AB00, 4'b0010);
        do_read(32'h0000_0040, 32'h1122_AB44, 4'h0);
        do_read(32'h1000_0013, 32'hDEAD_BEEF, 4'h0);      // upper and byte-offset bits ignored
        do_oor(1'b1, 32'hFFFF_FFFC);
        do_oor(1'b0, 32'hFFFF_0000);
        do_write(32'hFFFE_FFFC, 32'hCAFE_F00D, 4'hF);
        do_read(32'hFFFE_FFFC, 32'hCAFE_F00D, 4'h0);
        do_write(32'h0000_0010, 32'hAA00_00BB, 4'b1001);
        do_read(32'h0000_0010, 32'hAAAD_BEBB, 4'hF);      // read wins, write dropped

        // Reset while both instances sit in RD_WAIT.
        e.kind = K_ABORT; e.addr = 10'h010; e.data = 32'h0; e.rd = 1'b1;
        exp_ev.push_back(e);
        issue(1'b1, 32'h0000_0040, 32'h0, 4'h0);
        @(posedge clk); #2;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
        repeat (8) @(posedge clk);
        do_read(32'h0000_0040, 32'h1122_AB44, 4'h0);

`ifdef RAM_PORT_POSTED_WRITE_EN
        posted_pair(32'h0000_0080, 32'h0102_0304, 32'h0000_0084, 32'h0506_0708, 1'b0);
        do_read(32'h0000_0080, 32'h0102_0304, 4'h0);
        do_read(32'h0000_0084, 32'h0506_0708, 4'h0);
        do_write(32'h0000_008C, 32'h7777_7777, 4'hF);
        posted_pair(32'h0000_0088, 32'h0A0B_0C0D, 32'h0000_008C, 32'hEEEE_EEEE, 1'b1);
        do_read(32'h0000_008C, 32'h7777_7777, 4'h0);
        do_read(32'h0000_0088, 32'h0A0B_0C0D, 4'h0);
`endif

        repeat (4) @(posedge clk);
        end_chk = 1'b1;
        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
